// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin arbiter sharing one combinational FP adder between two requesters
module fp_add_arbiter #(
  parameter int WIDTH      = 32,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic             last_id_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] add_a_q, add_b_q, rsp_data_q;
  logic             rsp_valid_q, rsp_id_q, rsp_ovf_q;

  logic             grant0, grant1;
  logic             accept0, accept1, accept;
  logic             cnt_done, rsp_fire;

  // Round-robin grant: a lone requester always wins, a tie goes to the one not served last
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_id_q);
    grant1 = req1_valid && (!req0_valid || !last_id_q);
  end

  assign accept0  = req0_valid && req0_ready;
  assign accept1  = req1_valid && req1_ready;
  assign accept   = accept0 || accept1;
  assign cnt_done = (cnt_q == 4'd1);
  assign rsp_fire = rsp_valid_q && rsp_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept -> hold operands for the settle window -> present response
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)   state_d = S_WAIT;
      S_WAIT:  if (cnt_done) state_d = S_RESP;
      S_RESP:  if (rsp_fire) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state: readys only while idle, busy everywhere else
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = (state_q != S_IDLE);
    if (state_q == S_IDLE) begin
      req0_ready = grant0;
      req1_ready = grant1;
    end
  end

  // Datapath: latch operands on accept, count the settle window, capture the adder result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_id_q   <= 1'b1;
      cnt_q       <= 4'd0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            add_a_q   <= accept1 ? req1_a : req0_a;
            add_b_q   <= accept1 ? req1_b : req0_b;
            rsp_id_q  <= accept1;
            last_id_q <= accept1;
            cnt_q     <= 4'(SETTLE_CYC);
          end
        end
        S_WAIT: begin
          if (cnt_done) begin
            rsp_data_q  <= add_sum;
            rsp_ovf_q   <= add_ovf;
            rsp_valid_q <= 1'b1;
            cnt_q       <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_fire) rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one combinational 32-bit floating-point adder between two requesters.
- Performs round-robin arbitration and accepts one operand pair at a time.
- Drives the adder operand bus from registers, waits a fixed settle time, then captures the sum and overflow flag.
- Returns the result with the requester's ID over a valid/ready response channel.
- Sits between the FP ALU front-end issue logic and the shared adder instance.

Parameters:
- WIDTH, 32: operand/result width (IEEE-754 single).
- SETTLE_CYC, 2: cycles the adder operands are held before the result is captured; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 pair accepted this cycle when high together with req0_valid.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req1_valid  in  1  requester 1 has an operand pair.
- req1_ready  out  1  requester 1 pair accepted this cycle when high together with req1_valid.
- req1_a  in  WIDTH  requester 1 operand A.
- req1_b  in  WIDTH  requester 1 operand B.
- add_a  out  WIDTH  registered operand to adder para1.
- add_b  out  WIDTH  registered operand to adder para2.
- add_sum  in  WIDTH  adder out.
- add_ovf  in  1  adder under_overflow.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  WIDTH  captured sum.
- rsp_ovf  out  1  captured overflow flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, last_id=1 (so req0 wins the first tie).
  - add_a, add_b, rsp_data = 0; rsp_valid, rsp_id, rsp_ovf, busy = 0; counter = 0.
  - Reset mid-operation discards the in-flight transaction; no response is ever produced for it.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Grant is computed combinationally.
  - Only one valid: grant that requester.
  - Both valid: grant the requester != last_id.
  - reqN_ready is high only for the granted requester and only in IDLE; both readys are 0 in WAIT and RESP.
  - Accept (cycle T): on valid&ready, latch reqN_a/reqN_b into add_a/add_b, latch rsp_id=N, set last_id=N, load counter=SETTLE_CYC, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter equals 1 (cycle T+SETTLE_CYC), capture add_sum into rsp_data and add_ovf into rsp_ovf, set rsp_valid=1, go to RESP.
  - rsp_valid is first visible at T+SETTLE_CYC+1.
- RESP:
  - rsp_valid, rsp_id, rsp_data, rsp_ovf are held stable until rsp_ready=1.
  - On handshake: rsp_valid=0, go to IDLE.
  - add_a/add_b keep their last values (no clear).
- Single outstanding transaction; no pipelining.
- Best-case issue-to-issue spacing is SETTLE_CYC+2 cycles: accept T, respond T+SETTLE_CYC+1, next accept T+SETTLE_CYC+2.
- Requester rules:
  - Requesters must hold valid and operands until ready.
  - A requester that drops valid before grant loses nothing; no state is kept for it.
  - Grant fairness: while both are continuously valid, grants strictly alternate.
- rsp_ready held low indefinitely stalls the block in RESP; requests are not accepted meanwhile.
- Operand and result values pass through unmodified; no arithmetic is performed in this block.
- SETTLE_CYC=1: capture occurs in the cycle immediately after accept.

Test Plan:
- Single request: after reset, req0 a=0x3F800000 (1.0), b=0x40000000 (2.0), rsp_ready=1, SETTLE_CYC=2 -> req0_ready high in cycle 0; rsp_valid high in cycle 3 only; rsp_id=0, rsp_data=0x40400000 (3.0), rsp_ovf=0.
- Simultaneous requests: both valid from reset, req1 a=0x40000000, b=0x40000000 -> req0 granted first, then req1 at cycle 4; rsp_id sequence 0,1; req1 result 0x40800000.
- Sustained contention: both valid for 6 transactions -> grants alternate 0,1,0,1,0,1; no grant during busy; accepts spaced exactly 4 cycles apart.
- Response backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_id held stable, req readys stay 0, busy=1; release -> handshake, IDLE next cycle.
- Overflow pass-through: a=b=0x7F000000 with the real adder -> rsp_ovf=1, rsp_data=0x7F800000.
- Reset mid-op: assert rst_n=0 during WAIT -> next cycle all outputs zero, no rsp_valid afterward; the next request is granted to req0 on a tie.
